// File: rtl/aes128_inv_key_sched.sv
// AES-128 decrypt round-key source: expands the cipher key forward to round 10,
// then streams rk10..rk0 by inverse key expansion over a valid/ready handshake.
module aes128_inv_key_sched #(
    parameter int NUM_ROUNDS = 10,
    parameter int IDX_W      = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [127:0]     key_i,
    output logic             busy_o,
    output logic             rk_valid_o,
    input  logic             rk_ready_i,
    output logic [127:0]     rk_o,
    output logic [IDX_W-1:0] rk_idx_o,
    output logic             done_o
);

    generate
        if (NUM_ROUNDS != 32'sd10 || IDX_W < 32'sd4) begin : g_param_check
            $error("aes128_inv_key_sched supports only NUM_ROUNDS=10 with IDX_W>=4");
        end
    endgenerate

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] EXPAND = 2'd1;
    localparam logic [1:0] EMIT   = 2'd2;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] base;
        base = 11'd2047 - {b, 3'b000};
        sbox = SBOX_TABLE[base -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        sub_word = {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        rot_word = {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] round);
        case (round)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    logic [1:0]   state_r;
    logic [127:0] key_r;
    logic [3:0]   cnt_r;
    logic         valid_r;
    logic         busy_r;
    logic         done_r;

    logic [31:0]  w0_s, w1_s, w2_s, w3_s;
    logic [31:0]  sbox_in_s;
    logic [31:0]  sub_s;
    logic [31:0]  rcon_word_s;
    logic [31:0]  n0_s, n1_s, n2_s, n3_s;
    logic [31:0]  p0_s, p1_s, p2_s, p3_s;
    logic [127:0] fwd_key_s;
    logic [127:0] inv_key_s;

    // Forward and inverse round steps sharing one 4-byte S-box; cnt_r is the round index in both phases.
    always_comb begin
        w0_s = key_r[127:96];
        w1_s = key_r[95:64];
        w2_s = key_r[63:32];
        w3_s = key_r[31:0];
        if (state_r == EMIT) begin
            sbox_in_s = w3_s ^ w2_s;
        end else begin
            sbox_in_s = w3_s;
        end
        sub_s       = sub_word(rot_word(sbox_in_s));
        rcon_word_s = {rcon(cnt_r), 24'h000000};
        n0_s        = w0_s ^ sub_s ^ rcon_word_s;
        n1_s        = n0_s ^ w1_s;
        n2_s        = n1_s ^ w2_s;
        n3_s        = n2_s ^ w3_s;
        p3_s        = w3_s ^ w2_s;
        p2_s        = w2_s ^ w1_s;
        p1_s        = w1_s ^ w0_s;
        p0_s        = w0_s ^ sub_s ^ rcon_word_s;
        fwd_key_s   = {n0_s, n1_s, n2_s, n3_s};
        inv_key_s   = {p0_s, p1_s, p2_s, p3_s};
    end

    // Schedule FSM: key register doubles as the rk_o output register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            key_r   <= 128'h0;
            cnt_r   <= 4'd0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        key_r   <= key_i;
                        cnt_r   <= 4'd1;
                        busy_r  <= 1'b1;
                        state_r <= EXPAND;
                    end
                end
                EXPAND: begin
                    key_r <= fwd_key_s;
                    if (cnt_r == 4'd10) begin
                        state_r <= EMIT;
                        valid_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                EMIT: begin
                    if (valid_r && rk_ready_i) begin
                        if (cnt_r == 4'd0) begin
                            state_r <= IDLE;
                            valid_r <= 1'b0;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            key_r <= inv_key_s;
                            cnt_r <= cnt_r - 4'd1;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o     = busy_r;
    assign rk_valid_o = valid_r;
    assign rk_o       = key_r;
    assign rk_idx_o   = IDX_W'(cnt_r);
    assign done_o     = done_r;

endmodule
